life_keys: RTL

Front-end conditioning stage for the Game of Life board's six push-buttons (next, flip, down, up, left, right). It synchronises each raw button to clk, debounces it, and emits a single-cycle press pulse. Direction keys also get hold-to-repeat pulses. Its outputs drive the key_nxt, key_flip, key_down, key_up, key_left and key_right inputs of the life top level directly.

---
 rtl/life_keys.sv | 119 +++++++++++
 1 files changed

// File: rtl/life_keys.sv
// life_keys: push-button front end for the Game of Life board.
// Each of the six buttons is polarity-normalised, run through a 2-FF
// synchroniser and a counting debouncer. The result is turned into a
// registered one-cycle press pulse. Direction keys can also emit
// hold-to-repeat pulses.
module life_keys #(
    parameter int unsigned DB_W         = 16,
    parameter int unsigned DB_CNT       = 50000,
    parameter int unsigned RPT_W        = 24,
    parameter int unsigned REPEAT_DELAY = 6000000,
    parameter int unsigned REPEAT_RATE  = 2000000,
    parameter bit          ACTIVE_LOW   = 1'b1,
    // Bit order {right, left, up, down, flip, nxt}.
    parameter logic [5:0]  REPEAT_MASK  = 6'b111100
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_nxt,
    input  logic btn_flip,
    input  logic btn_down,
    input  logic btn_up,
    input  logic btn_left,
    input  logic btn_right,
    output logic key_nxt,
    output logic key_flip,
    output logic key_down,
    output logic key_up,
    output logic key_left,
    output logic key_right
);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CNT - 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_RATE - 1);

    logic [5:0] btn_raw;
    logic [5:0] btn_norm;
    logic [5:0] key_vec;

    assign btn_raw  = {btn_right, btn_left, btn_up, btn_down, btn_flip, btn_nxt};
    // After this point a pressed button always reads 1.
    assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

    assign key_nxt   = key_vec[0];
    assign key_flip  = key_vec[1];
    assign key_down  = key_vec[2];
    assign key_up    = key_vec[3];
    assign key_left  = key_vec[4];
    assign key_right = key_vec[5];

    for (genvar k = 0; k < 6; k++) begin : g_key
        logic             s1_q;
        logic             s2_q;
        logic             st_q;
        logic             st_d;
        logic             key_q;
        logic             key_d;
        logic [DB_W-1:0]  dc_q;
        logic [DB_W-1:0]  dc_d;
        logic [RPT_W-1:0] rc_q;
        logic [RPT_W-1:0] rc_d;

        // Debounce: accept a new level only after DB_CNT consecutive differing samples.
        always_comb begin
            st_d = st_q;
            dc_d = dc_q + 1'b1;
            if (s2_q == st_q) begin
                dc_d = '0;
            end else if (dc_q == DB_LAST) begin
                st_d = s2_q;
                dc_d = '0;
            end
        end

        // Press pulse on the debounced rising edge, then optional auto-repeat while held.
        always_comb begin
            key_d = 1'b0;
            rc_d  = rc_q;
            if (!st_d) begin
                // Released (or releasing this edge): no pulse, repeat timer idle.
                rc_d = '0;
            end else if (!st_q) begin
                key_d = 1'b1;
                if (REPEAT_MASK[k]) begin
                    rc_d = RPT_FIRST;
                end
            end else if (REPEAT_MASK[k]) begin
                if (rc_q == '0) begin
                    key_d = 1'b1;
                    rc_d  = RPT_NEXT;
                end else begin
                    rc_d = rc_q - 1'b1;
                end
            end
        end

        // State registers: synchroniser, debouncer, repeat timer and output pulse.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                st_q  <= 1'b0;
                dc_q  <= '0;
                rc_q  <= '0;
                key_q <= 1'b0;
            end else begin
                s1_q  <= btn_norm[k];
                s2_q  <= s1_q;
                st_q  <= st_d;
                dc_q  <= dc_d;
                rc_q  <= rc_d;
                key_q <= key_d;
            end
        end

        assign key_vec[k] = key_q;
    end

endmodule
